nukv_privacy_route_ctrl: RTL

//  Sequencer for the privacy datapath. Takes one routing command per value and steers its beats to one lane:

---
 rtl/nukv_privacy_pkg.sv | 24 ++
 rtl/nukv_privacy_route_ctrl_if.sv | 47 ++++
 rtl/nukv_privacy_order_q.sv | 50 +++++
 rtl/nukv_privacy_route_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nukv_privacy_pkg.sv
// Shared types for the privacy datapath sequencer: lane ids, the matrix-load opcode, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nukv_privacy_pkg;

  typedef enum logic [1:0] {
    LANE_BYPASS = 2'd0,
    LANE_ROTATE = 2'd1,
    LANE_MATRIX = 2'd2
  } lane_e;

  localparam logic [7:0] OPCODE_MATRIX = 8'hFE;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_e;

  // One-hot lane_valid pattern for a lane id.
  function automatic logic [2:0] lane_onehot(lane_e l);
    return 3'b001 << l;
  endfunction

endpackage

// File: rtl/nukv_privacy_route_ctrl_if.sv
// Handshake bundle of the privacy route controller: command, input beats, lane fan-out, lane returns, merged output.
// Latency: n/a (wires only).
// Backpressure: every channel is valid/ready; slave = controller view, master = environment view.
interface nukv_privacy_route_ctrl_if #(
  parameter int MW = 512
);
  logic [7:0]      cmd_op;
  logic            cmd_valid;
  logic            cmd_ready;

  logic [MW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;

  logic [MW-1:0]   lane_data;
  logic            lane_last;
  logic [2:0]      lane_valid;
  logic [2:0]      lane_ready;

  logic [2*MW-1:0] ret_data;
  logic [1:0]      ret_valid;
  logic [1:0]      ret_last;
  logic [1:0]      ret_ready;

  logic [MW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;

  modport slave (
    input  cmd_op, cmd_valid, output cmd_ready,
    input  in_data, in_valid, in_last, output in_ready,
    output lane_data, lane_last, lane_valid, input lane_ready,
    input  ret_data, ret_valid, ret_last, output ret_ready,
    output out_data, out_valid, out_last, input out_ready
  );

  modport master (
    output cmd_op, cmd_valid, input cmd_ready,
    output in_data, in_valid, in_last, input in_ready,
    input  lane_data, lane_last, lane_valid, output lane_ready,
    output ret_data, ret_valid, ret_last, input ret_ready,
    input  out_data, out_valid, out_last, output out_ready
  );

endinterface

// File: rtl/nukv_privacy_order_q.sv
// Order queue: 1-bit-wide synchronous FIFO recording which return lane each in-flight value went to.
// Latency: push visible at head one cycle later; head is a combinational read of the oldest entry.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: i_clk/i_rst, i_push/i_din write side, i_pop read side, o_full/o_empty status, o_head oldest entry.
module nukv_privacy_order_q #(
  parameter int ADDR_BITS = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [ADDR_BITS:0] r_wr_ptr;
  logic [ADDR_BITS:0] r_rd_ptr;
  logic [DEPTH-1:0]   r_mem;
  logic               w_do_push;
  logic               w_do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]) &&
                   (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);
  assign o_head  = r_mem[r_rd_ptr[ADDR_BITS-1:0]];

  assign w_do_pop  = i_pop && !o_empty;
  // At full a simultaneous pop frees the slot being written.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= i_din;
  end

endmodule

// File: rtl/nukv_privacy_route_ctrl.sv
// Privacy datapath sequencer: steers each value to bypass, rotate or matrix-load lane, re-merges returns in order.
// Latency: zero-latency steering in DISPATCH; output is a combinational mux of the lane return at queue head.
// Backpressure: per-lane credits and queue occupancy gate cmd_ready; in_ready follows the selected lane's ready.
// Ports: i_clk/i_rst; io_bus (cmd/in/lane/ret/out handshakes); o_matrix_loaded; o_err_no_matrix (sticky).
// Optional macro PRIV_ROUTE_STATS_EN adds o_stat_bypass/o_stat_rotate/o_stat_matrix accepted-command counters.
module nukv_privacy_route_ctrl
  import nukv_privacy_pkg::*;
#(
  parameter int MEMORY_WIDTH        = 512,
  parameter int VALUE_SIZE_BYTES_NO = 2,
  parameter int ORDER_ADDR_BITS     = 5,
  parameter int MAX_OUTSTANDING     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  nukv_privacy_route_ctrl_if.slave  io_bus,
  output logic                      o_matrix_loaded,
  output logic                      o_err_no_matrix
`ifdef PRIV_ROUTE_STATS_EN
  ,
  output logic [31:0]               o_stat_bypass,
  output logic [31:0]               o_stat_rotate,
  output logic [31:0]               o_stat_matrix
`endif
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

  if (VALUE_SIZE_BYTES_NO * 8 + 8 > MEMORY_WIDTH) begin : g_bad_cfg
    $error("opcode byte lies outside the data beat");
  end

  state_e              r_state, w_state_nxt;
  lane_e               r_sel, w_sel_nxt;
  logic [1:0][CW-1:0]  r_cnt;
  logic                r_matrix_loaded;
  logic                r_err_no_matrix;

  logic        w_is_matrix, w_rot_req, w_tgt_rot, w_credit_ok;
  lane_e       w_tgt;
  logic        w_cmd_ready, w_in_ready;
  logic [2:0]  w_lane_valid;
  logic        w_cmd_fire, w_beat_fire, w_push, w_pop;
  logic        w_q_full, w_q_empty, w_head;
  logic [1:0]  w_inc, w_dec;
  logic        w_out_valid, w_out_last;
  logic [1:0]  w_ret_ready;

  // Command decode; an unloaded matrix turns a rotate request into a bypass.
  assign w_is_matrix = (io_bus.cmd_op == OPCODE_MATRIX);
  assign w_rot_req   = !w_is_matrix && io_bus.cmd_op[0];
  assign w_tgt_rot   = w_rot_req && r_matrix_loaded;
  assign w_tgt       = w_is_matrix ? LANE_MATRIX : (w_tgt_rot ? LANE_ROTATE : LANE_BYPASS);
  assign w_credit_ok = w_tgt_rot ? (r_cnt[1] < MAX_CNT) : (r_cnt[0] < MAX_CNT);

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cmd_ready  = 1'b0;
    w_in_ready   = 1'b0;
    w_lane_valid = 3'b000;
    if (!i_rst) begin
      unique case (r_state)
        ST_IDLE: begin
          // Matrix loads bypass both queue and credits.
          w_cmd_ready = w_is_matrix || (!w_q_full && w_credit_ok);
          if (io_bus.cmd_valid && w_cmd_ready) begin
            w_sel_nxt   = w_tgt;
            w_state_nxt = ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          w_lane_valid = io_bus.in_valid ? lane_onehot(r_sel) : 3'b000;
          unique case (r_sel)
            LANE_ROTATE: w_in_ready = io_bus.lane_ready[1];
            LANE_MATRIX: w_in_ready = io_bus.lane_ready[2];
            default:     w_in_ready = io_bus.lane_ready[0];
          endcase
          if (io_bus.in_valid && w_in_ready && io_bus.in_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_cmd_fire  = io_bus.cmd_valid && w_cmd_ready;
  assign w_beat_fire = io_bus.in_valid && w_in_ready;
  assign w_push      = w_cmd_fire && !w_is_matrix;

  assign io_bus.cmd_ready  = w_cmd_ready;
  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.lane_valid = w_lane_valid;
  assign io_bus.lane_data  = io_bus.in_data;
  assign io_bus.lane_last  = io_bus.in_last;

  nukv_privacy_order_q #(
    .ADDR_BITS (ORDER_ADDR_BITS)
  ) u_order_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_tgt_rot),
    .i_pop   (w_pop),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_head  (w_head)
  );

  // Only the lane at the queue head may return; others wait even if valid.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_ret_ready = 2'b00;
    if (!w_q_empty && !i_rst) begin
      if (w_head) begin
        w_out_valid    = io_bus.ret_valid[1];
        w_out_last     = io_bus.ret_last[1];
        w_ret_ready[1] = io_bus.out_ready;
      end else begin
        w_out_valid    = io_bus.ret_valid[0];
        w_out_last     = io_bus.ret_last[0];
        w_ret_ready[0] = io_bus.out_ready;
      end
    end
  end

  assign io_bus.out_data  = w_head ? io_bus.ret_data[2*MEMORY_WIDTH-1:MEMORY_WIDTH]
                                   : io_bus.ret_data[MEMORY_WIDTH-1:0];
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_last  = w_out_last;
  assign io_bus.ret_ready = w_ret_ready;

  assign w_pop = w_out_valid && io_bus.out_ready && w_out_last;
  assign w_inc = w_push ? (w_tgt_rot ? 2'b10 : 2'b01) : 2'b00;
  assign w_dec = w_pop  ? (w_head    ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= LANE_BYPASS;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Same-lane increment and decrement cancel; both directions saturate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != MAX_CNT)) r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_matrix_loaded <= 1'b0;
      r_err_no_matrix <= 1'b0;
    end else begin
      if (w_beat_fire && io_bus.in_last && (r_sel == LANE_MATRIX)) r_matrix_loaded <= 1'b1;
      if (w_cmd_fire && w_rot_req && !r_matrix_loaded)             r_err_no_matrix <= 1'b1;
    end
  end

  assign o_matrix_loaded = r_matrix_loaded;
  assign o_err_no_matrix = r_err_no_matrix;

`ifdef PRIV_ROUTE_STATS_EN
  logic [31:0] r_stat_bypass, r_stat_rotate, r_stat_matrix;

  // Counts reflect the lane actually used, i.e. after any downgrade.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_bypass <= '0;
      r_stat_rotate <= '0;
      r_stat_matrix <= '0;
    end else if (w_cmd_fire) begin
      unique case (w_tgt)
        LANE_ROTATE: r_stat_rotate <= r_stat_rotate + 1'b1;
        LANE_MATRIX: r_stat_matrix <= r_stat_matrix + 1'b1;
        default:     r_stat_bypass <= r_stat_bypass + 1'b1;
      endcase
    end
  end

  assign o_stat_bypass = r_stat_bypass;
  assign o_stat_rotate = r_stat_rotate;
  assign o_stat_matrix = r_stat_matrix;
`endif

endmodule
